// File: rtl/sd_modulator_if.sv
// rtl/sd_modulator_if.sv - sample input handshake for the sigma-delta transmitter
interface sd_modulator_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] sample_data;
    logic                     sample_valid;
    logic                     sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/sd_modulator.sv
// rtl/sd_modulator.sv - 1st/2nd-order sigma-delta bitstream transmitter
// Clocked (DSDOUT+SDCLK) or Manchester output, one-entry sample buffer.
module sd_modulator #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    input  logic             en,
    input  logic             mode,
    input  logic             order,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic [15:0]      osr,
    sd_modulator_if.slave    s_if,
    output logic             DSDOUT,
    output logic             SDCLK,
    output logic             busy,
    output logic             underrun
);
    localparam logic signed [25:0] FB_POS = 26'sd32768;
    localparam logic signed [25:0] FB_NEG = -26'sd32768;

    logic                     r_en, r_mode, r_order;
    logic [DIV_W-1:0]         r_div, r_hcnt;
    logic [15:0]              r_osr, r_bcnt;
    logic                     r_phase, r_bit, r_dout, r_full, r_underrun;
    logic signed [19:0]       r_i1;
    logic signed [23:0]       r_i2;
    logic signed [DATA_W-1:0] r_x, r_buf;

    logic                     w_hwrap, w_bit_tick, w_mid_tick, w_boundary, w_accept, w_bit;
    logic signed [25:0]       w_fb, w_i1_sum, w_i2_sum;
    logic signed [19:0]       w_i1_new;
    logic signed [23:0]       w_i2_new;

    assign w_hwrap    = (r_hcnt == r_div);
    assign w_bit_tick = w_hwrap & r_phase;
    assign w_mid_tick = w_hwrap & ~r_phase;
    assign w_boundary = w_bit_tick & (r_bcnt == r_osr - 16'd1);
    assign w_accept   = s_if.sample_valid & s_if.sample_ready;
    assign w_bit      = r_order ? ~r_i2[23] : ~r_i1[19];
    assign w_fb       = w_bit ? FB_POS : FB_NEG;

    // Integrators clamp instead of wrapping so an overdriven input cannot flip the loop sign.
    always_comb begin
        w_i1_sum = {{6{r_i1[19]}}, r_i1} + {{(26-DATA_W){r_x[DATA_W-1]}}, r_x} - w_fb;
        if (w_i1_sum > 26'sd524287)
            w_i1_new = 20'sh7FFFF;
        else if (w_i1_sum < -26'sd524288)
            w_i1_new = 20'sh80000;
        else
            w_i1_new = w_i1_sum[19:0];

        w_i2_sum = {{2{r_i2[23]}}, r_i2} + {{6{w_i1_new[19]}}, w_i1_new} - w_fb;
        if (w_i2_sum > 26'sd8388607)
            w_i2_new = 24'sh7FFFFF;
        else if (w_i2_sum < -26'sd8388608)
            w_i2_new = 24'sh800000;
        else
            w_i2_new = w_i2_sum[23:0];
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            r_en       <= 1'b0;
            r_mode     <= 1'b0;
            r_order    <= 1'b0;
            r_div      <= '0;
            r_osr      <= '0;
            r_hcnt     <= '0;
            r_bcnt     <= '0;
            r_phase    <= 1'b0;
            r_bit      <= 1'b0;
            r_dout     <= 1'b0;
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
            r_i1       <= '0;
            r_i2       <= '0;
            r_x        <= '0;
            r_buf      <= '0;
        end else begin
            r_en       <= en;
            r_underrun <= 1'b0;
            if (!en) begin
                r_hcnt  <= '0;
                r_bcnt  <= '0;
                r_phase <= 1'b0;
                r_bit   <= 1'b0;
                r_dout  <= 1'b0;
                r_full  <= 1'b0;
                r_i1    <= '0;
                r_i2    <= '0;
                r_x     <= '0;
                r_buf   <= '0;
            end else if (!r_en) begin
                r_mode  <= mode;
                r_order <= order;
                r_div   <= clkdiv;
                r_osr   <= (osr == 16'd0) ? 16'd1 : osr;
            end else begin
                if (w_hwrap) begin
                    r_hcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_hcnt  <= r_hcnt + DIV_W'(1);
                end

                if (w_bit_tick) begin
                    r_bit  <= w_bit;
                    r_i1   <= w_i1_new;
                    if (r_order)
                        r_i2 <= w_i2_new;
                    r_bcnt <= w_boundary ? 16'd0 : r_bcnt + 16'd1;
                    r_dout <= r_mode ? ~w_bit : w_bit;
                end else if (w_mid_tick && r_mode) begin
                    r_dout <= r_bit;
                end

                // Boundary sees the pre-edge buffer; a same-cycle accept refills it afterwards.
                if (w_boundary) begin
                    if (r_full) begin
                        r_x    <= r_buf;
                        r_full <= 1'b0;
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end
                if (w_accept) begin
                    r_buf  <= s_if.sample_data;
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign s_if.sample_ready = r_en & ~r_full;
    assign DSDOUT            = r_dout;
    assign SDCLK             = r_phase & ~r_mode;
    assign busy              = r_en;
    assign underrun          = r_underrun;
endmodule
